pr_pipe_slice: RTL

- Parametrised valid/ready register slice for partial-reconfiguration region boundaries, chained REG_LENGTH stages deep. Successor to the single-mode boundary pipe registers.
- Used per channel on every RPU PR wrapper interface: DMA write/read, descriptors and broadcast messages.
- Adds over the previous generation:
  - a flush input, so core_reset can empty descriptor channels without a full reset;
  - an occupancy output;
  - a lossy mode with a saturating drop counter, for channels whose sender ignores ready (broadcast-in).

---
 rtl/pr_pipe_pkg.sv | 18 +
 rtl/pr_pipe_slice_stage.sv | 92 +++++++++
 rtl/pr_pipe_slice.sv | 108 ++++++++++
 3 files changed

// File: rtl/pr_pipe_pkg.sv
// Shared constants and helpers for the partial-reconfiguration boundary pipe slice.
package pr_pipe_pkg;

  localparam int REG_BYPASS     = 0;
  localparam int REG_FWD        = 1;
  localparam int REG_SKID       = 2;
  localparam int MAX_REG_LENGTH = 8;

  // Per-stage held-beat count: a skid stage can hold up to two beats.
  typedef logic [1:0] stage_cnt_t;

  function automatic int occ_width(input int reg_length);
    int w;
    w = $clog2(2 * reg_length + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pr_pipe_slice_stage.sv
// One valid/ready register stage: forward register (REG_FWD) or registered-ready
// skid buffer (REG_SKID). Reports how many beats it currently holds.
module pr_pipe_stage
  import pr_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_TYPE   = REG_SKID
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output stage_cnt_t            count_o
);

  if (REG_TYPE == REG_FWD) begin : g_fwd
    logic                  main_vld_q, main_vld_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;

    assign s_ready_o = !main_vld_q || m_ready_i;
    assign m_valid_o = main_vld_q;
    assign m_data_o  = main_data_q;
    assign count_o   = {1'b0, main_vld_q};

    always_comb begin
      main_vld_d  = main_vld_q;
      main_data_d = main_data_q;
      if (s_ready_o) begin
        main_vld_d = s_valid_i;
        if (s_valid_i) main_data_d = s_data_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) main_vld_q <= 1'b0;
      else                  main_vld_q <= main_vld_d;
      main_data_q <= main_data_d;
    end
  end else begin : g_skid
    logic                  main_vld_q, main_vld_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  push, pop;

    // Ready comes straight from a flop, so m_ready never reaches s_ready.
    assign s_ready_o = !skid_vld_q;
    assign m_valid_o = main_vld_q;
    assign m_data_o  = main_data_q;
    assign count_o   = stage_cnt_t'({1'b0, main_vld_q}) + stage_cnt_t'({1'b0, skid_vld_q});
    assign push      = s_valid_i && !skid_vld_q;
    assign pop       = main_vld_q && m_ready_i;

    always_comb begin
      main_vld_d  = main_vld_q;
      main_data_d = main_data_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      if (!main_vld_q || pop) begin
        if (skid_vld_q) begin
          main_vld_d  = 1'b1;
          main_data_d = skid_data_q;
          skid_vld_d  = 1'b0;
        end else begin
          main_vld_d = push;
          if (push) main_data_d = s_data_i;
        end
      end else if (push) begin
        skid_vld_d  = 1'b1;
        skid_data_d = s_data_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
      end else begin
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
      end
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/pr_pipe_slice.sv
// Chained valid/ready slice for PR region boundaries, with flush, occupancy
// reporting and an optional lossy mode that counts beats the sender pushed anyway.
module pr_pipe_slice
  import pr_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_TYPE       = 2,
  parameter int REG_LENGTH     = 1,
  parameter bit LOSSLESS       = 1'b1,
  parameter int DROP_CNT_WIDTH = 16,
  parameter int OCC_WIDTH      = occ_width(REG_LENGTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OCC_WIDTH-1:0]      occupancy,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      drop_pulse
);

  if (REG_LENGTH < 1 || REG_LENGTH > MAX_REG_LENGTH || REG_TYPE > REG_SKID || REG_TYPE < 0)
  begin : g_bad_param
    $error("pr_pipe_slice: REG_LENGTH must be 1..%0d and REG_TYPE 0..2", MAX_REG_LENGTH);
  end

  logic                 core_ready;
  logic [OCC_WIDTH-1:0] occ_sum;

  if (REG_TYPE == REG_BYPASS) begin : g_bypass
    assign m_data     = s_data;
    assign m_valid    = s_valid && !flush;
    assign core_ready = m_ready;
    assign occ_sum    = '0;
  end else begin : g_chain
    logic [DATA_WIDTH-1:0] stg_data  [REG_LENGTH+1];
    logic                  stg_valid [REG_LENGTH+1];
    logic                  stg_ready [REG_LENGTH+1];
    stage_cnt_t            stg_cnt   [REG_LENGTH];

    // Nothing enters stage 0 while the slice is being reset or flushed.
    assign stg_data[0]           = s_data;
    assign stg_valid[0]          = s_valid && !rst && !flush;
    assign stg_ready[REG_LENGTH] = m_ready;
    assign m_data                = stg_data[REG_LENGTH];
    assign m_valid               = stg_valid[REG_LENGTH];
    assign core_ready            = stg_ready[0];

    for (genvar i = 0; i < REG_LENGTH; i++) begin : g_stage
      pr_pipe_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_TYPE   (REG_TYPE)
      ) u_stage (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .s_data_i  (stg_data[i]),
        .s_valid_i (stg_valid[i]),
        .s_ready_o (stg_ready[i]),
        .m_data_o  (stg_data[i+1]),
        .m_valid_o (stg_valid[i+1]),
        .m_ready_i (stg_ready[i+1]),
        .count_o   (stg_cnt[i])
      );
    end

    always_comb begin
      occ_sum = '0;
      for (int i = 0; i < REG_LENGTH; i++) begin
        occ_sum = occ_sum + OCC_WIDTH'(stg_cnt[i]);
      end
    end
  end

  assign s_ready   = core_ready && !rst && !flush;
  assign occupancy = occ_sum;

  logic                      drop;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      drop_pulse_q;

  // A beat the sender pushes without ready is lost; flush/reset cycles never count.
  assign drop = !LOSSLESS && s_valid && !s_ready && !rst && !flush;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop;
    end
  end

  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule
